imem_responder: RTL

Instruction-memory responder for the memory side of the instruction cache refill interface.
- Accepts single-word refill requests (mem_req_valid/mem_req_addr).
- Reads an internal word array.
- Returns the word with mem_resp_valid after a fixed, parameterised latency.
- A side load port lets the testbench/boot logic preload program words.

---
 rtl/imem_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts single-word refill requests, reads the
// internal word array, and returns the word after a fixed LATENCY. A side load
// port preloads program words and may write in any state.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned LATENCY     = 3,
  parameter logic [31:0] FILL_WORD   = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_req_valid,
  input  logic [31:0]          mem_req_addr,
  output logic                 mem_req_ready,
  output logic                 mem_resp_valid,
  output logic [31:0]          mem_resp_data,
  output logic                 mem_resp_err,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data,
  output logic [15:0]          req_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [15:0]    count_q, count_d;
  logic [31:0]    data_q, data_d;
  logic           err_q, err_d;
  logic           capture;
  logic [31:0]    cap_addr;
  logic           cap_err;
  logic [ADDR_BITS-1:0] cap_idx;
  logic [31:0]    mem_q [DEPTH_WORDS];

  // Next-state and handshake outputs for the request/response sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    count_d        = count_q;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    capture        = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          addr_d  = mem_req_addr;
          count_d = count_q + 16'd1;
          if (LATENCY == 1) begin
            state_d = RESP;
            capture = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      RESP: begin
        mem_resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response word selection; with LATENCY==1 the capture edge is the accept
  // edge, so the live request address is used instead of the latched one.
  always_comb begin
    cap_addr = (state_q == IDLE) ? mem_req_addr : addr_q;
    cap_err  = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (ADDR_BITS + 2)) != '0);
    cap_idx  = cap_addr[ADDR_BITS+1:2];
    data_d   = data_q;
    err_d    = err_q;
    if (capture) begin
      err_d  = cap_err;
      data_d = cap_err ? FILL_WORD : mem_q[cap_idx];
    end
  end

  // Sequencer state, request latch, counters and held response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Word array write port; not reset so preloaded contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign mem_resp_data = data_q;
  assign mem_resp_err  = err_q;
  assign req_count     = count_q;

endmodule
